// File: rtl/mxv_cmd_scheduler_pkg.sv
// Shared types and constants for the MxV command scheduler.
package mxv_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_GETLEN, S_GETCMD, S_ROWIDX, S_PAYLOAD, S_TAIL,
    S_EXEC, S_TXLOAD, S_TXBYTE
  } state_e;

  localparam logic [7:0] SOF = 8'hFE;
  localparam logic [7:0] EOF = 8'hEF;

  localparam logic [7:0] CMD_SET_N    = 8'h01;
  localparam logic [7:0] CMD_LOAD_VEC = 8'h02;
  localparam logic [7:0] CMD_LOAD_ROW = 8'h03;
  localparam logic [7:0] CMD_RUN      = 8'h04;

  // LEN a command must carry for the current N; 0 marks an unknown command.
  function automatic int req_len(input logic [7:0] cmd, input int n);
    case (cmd)
      CMD_SET_N:    return 2;
      CMD_LOAD_VEC: return 1 + n;
      CMD_LOAD_ROW: return 2 + n;
      CMD_RUN:      return 1;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/mxv_cmd_scheduler_if.sv
// Bus bundle between the scheduler and UART / memories / MxV datapath.
// res_data must reflect res_addr as updated on the previous clock edge.
interface mxv_if #(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int ADDR_W = $clog2(MAX_N*MAX_N)
);
  localparam int NW  = $clog2(MAX_N+1);
  localparam int RAW = $clog2(MAX_N);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [NW-1:0]     n_size;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              done;
  logic [RAW-1:0]    res_addr;
  logic [RES_W-1:0]  res_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, done, res_data, tx_ready,
    output n_size, wr_en, wr_sel, wr_addr, wr_data, start, res_addr,
           tx_data, tx_valid, busy, err
  );

  modport slave (
    output rx_data, rx_valid, done, res_data, tx_ready,
    input  n_size, wr_en, wr_sel, wr_addr, wr_data, start, res_addr,
           tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/mxv_cmd_scheduler_tx_serializer.sv
// Splits one result word into bytes, MSB first, over a valid/ready handshake.
module mxv_tx_serializer #(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [RES_W-1:0] word_i,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             word_done_o
);
  localparam int NB = RES_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [RES_W-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             vld_q;
  logic             last;

  assign last        = (int'(cnt_q) == NB - 1);
  assign tx_data_o   = sh_q[RES_W-1 -: 8];
  assign tx_valid_o  = vld_q;
  assign word_done_o = vld_q & tx_ready_i & last;

  // Load a fresh word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      sh_q  <= word_i;
      cnt_q <= '0;
      vld_q <= 1'b1;
    end else if (vld_q && tx_ready_i) begin
      sh_q <= sh_q << 8;
      if (last) vld_q <= 1'b0;
      else      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/mxv_cmd_scheduler.sv
// Frame parser and run/transmit sequencer for the MxV engine.
module mxv_cmd_scheduler
  import mxv_pkg::*;
#(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int ADDR_W = $clog2(MAX_N*MAX_N)
) (
  input  logic clk,
  input  logic reset,
  mxv_if.master bus
);
  localparam int NW  = $clog2(MAX_N+1);
  localparam int RAW = $clog2(MAX_N);

  state_e            state_q;
  logic [NW-1:0]     n_size_q;
  logic [7:0]        len_q, cmd_q, pend_q;
  logic [RAW-1:0]    row_q, col_q, res_addr_q;
  logic              wr_en_q, wr_sel_q, start_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy, load, word_done, col_last, res_last;

  assign busy     = (state_q == S_EXEC) || (state_q == S_TXLOAD) || (state_q == S_TXBYTE);
  assign load     = (state_q == S_TXLOAD);
  assign col_last = (int'(col_q) == int'(n_size_q) - 1);
  assign res_last = (int'(res_addr_q) == int'(n_size_q) - 1);

  assign bus.n_size   = n_size_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_sel   = wr_sel_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.start    = start_q;
  assign bus.res_addr = res_addr_q;
  assign bus.busy     = busy;
  assign bus.err      = err_q;

  mxv_tx_serializer #(.RES_W(RES_W)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .word_i     (bus.res_data),
    .tx_ready_i (bus.tx_ready),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .word_done_o(word_done)
  );

  // Main FSM: one received byte per cycle while parsing, then run and drain results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_size_q   <= NW'(MAX_N);
      len_q      <= '0;
      cmd_q      <= '0;
      pend_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      res_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      err_q   <= bus.rx_valid && busy;  // bytes arriving while busy are dropped
      case (state_q)
        S_IDLE:
          if (bus.rx_valid && bus.rx_data == SOF) state_q <= S_GETLEN;
        S_GETLEN:
          if (bus.rx_valid) begin
            len_q   <= bus.rx_data;
            state_q <= S_GETCMD;
          end
        S_GETCMD:
          if (bus.rx_valid) begin
            cmd_q <= bus.rx_data;
            col_q <= '0;
            if (req_len(bus.rx_data, int'(n_size_q)) == 0 ||
                req_len(bus.rx_data, int'(n_size_q)) != int'(len_q)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (bus.rx_data == CMD_LOAD_ROW) state_q <= S_ROWIDX;
            else if (bus.rx_data == CMD_RUN)          state_q <= S_TAIL;
            else                                      state_q <= S_PAYLOAD;
          end
        S_ROWIDX:
          if (bus.rx_valid) begin
            if (int'(bus.rx_data) >= int'(n_size_q)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              row_q   <= RAW'(bus.rx_data);
              state_q <= S_PAYLOAD;
            end
          end
        S_PAYLOAD:
          if (bus.rx_valid) begin
            if (cmd_q == CMD_SET_N) begin
              pend_q  <= bus.rx_data;
              state_q <= S_TAIL;
            end else begin
              wr_en_q   <= 1'b1;
              wr_sel_q  <= (cmd_q == CMD_LOAD_ROW);
              wr_data_q <= DATA_W'(bus.rx_data);
              wr_addr_q <= (cmd_q == CMD_LOAD_ROW)
                           ? ADDR_W'(row_q) * ADDR_W'(MAX_N) + ADDR_W'(col_q)
                           : ADDR_W'(col_q);
              if (col_last) state_q <= S_TAIL;
              else          col_q   <= col_q + RAW'(1);
            end
          end
        S_TAIL:
          if (bus.rx_valid) begin
            state_q <= S_IDLE;
            if (bus.rx_data != EOF) begin
              err_q <= 1'b1;
            end else if (cmd_q == CMD_SET_N) begin
              if (pend_q >= 8'd1 && int'(pend_q) <= MAX_N) n_size_q <= NW'(pend_q);
              else                                         err_q    <= 1'b1;
            end else if (cmd_q == CMD_RUN) begin
              start_q <= 1'b1;
              state_q <= S_EXEC;
            end
          end
        S_EXEC:
          if (bus.done) begin
            res_addr_q <= '0;
            state_q    <= S_TXLOAD;
          end
        S_TXLOAD:
          state_q <= S_TXBYTE;
        S_TXBYTE:
          if (word_done) begin
            if (res_last) state_q <= S_IDLE;
            else begin
              res_addr_q <= res_addr_q + RAW'(1);
              state_q    <= S_TXLOAD;
            end
          end
        default:
          state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mxv_cmd_scheduler.sv
// Scoreboard bench: a frame-level model queues expected writes/bytes/events,
// independent monitors pop and compare against what the scheduler emits.
module tb_mxv_cmd_scheduler;
  localparam int MAX_N  = 8;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mxv_if #(.MAX_N(MAX_N)) bus ();
  mxv_cmd_scheduler #(.MAX_N(MAX_N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int m_n = MAX_N;
  int err_exp = 0, err_seen = 0, start_exp = 0, start_seen = 0;
  logic [14:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] res_mem [MAX_N];
  int tx_mode = 0, tx_bidx = 0;

  assign bus.res_data = res_mem[bus.res_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h with nothing expected", nm, act);
  endtask

  // Frame-level reference: effects of one complete frame on N, writes, err, run.
  function automatic bit model_frame(input logic [7:0] f[$]);
    int len, need;
    logic [7:0] cmd;
    len = int'(f[1]);
    cmd = f[2];
    case (cmd)
      8'h01: need = 2;
      8'h02: need = 1 + m_n;
      8'h03: need = 2 + m_n;
      8'h04: need = 1;
      default: need = -1;
    endcase
    if (len != need) begin err_exp++; return 1'b0; end
    if (cmd == 8'h03 && int'(f[3]) >= m_n) begin err_exp++; return 1'b0; end
    if (cmd == 8'h02)
      for (int c = 0; c < m_n; c++) exp_wr.push_back({1'b0, ADDR_W'(c), f[3+c]});
    if (cmd == 8'h03)
      for (int c = 0; c < m_n; c++)
        exp_wr.push_back({1'b1, ADDR_W'(int'(f[3]) * MAX_N + c), f[4+c]});
    if (f[2+len] != 8'hEF) begin err_exp++; return 1'b0; end
    if (cmd == 8'h01) begin
      if (f[3] >= 8'd1 && int'(f[3]) <= MAX_N) m_n = int'(f[3]);
      else err_exp++;
    end
    return (cmd == 8'h04);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  task automatic settle_check(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_n_size"}, int'(bus.n_size), m_n);
    chk({tag, "_err_cnt"}, err_seen, err_exp);
    chk({tag, "_start_cnt"}, start_seen, start_exp);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_sel"}, bus.wr_sel, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_res_addr"}, bus.res_addr, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_tx_valid"}, bus.tx_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_n_size"}, int'(bus.n_size), MAX_N);
  endtask

  task automatic do_run(input int mode, input bit busy_byte);
    logic [7:0] f[$];
    int t, s0;
    f = '{8'hFE, 8'h01, 8'h04, 8'hEF};
    if (model_frame(f)) start_exp++;
    for (int i = 0; i < m_n; i++) begin
      exp_tx.push_back(res_mem[i][15:8]);
      exp_tx.push_back(res_mem[i][7:0]);
    end
    tx_mode = mode;
    tx_bidx = 0;
    s0 = start_seen;
    send_frame(f, 1'b0);
    t = 0;
    while (start_seen == s0 && t < 20) begin @(negedge clk); t++; end
    chk("run_start_cnt", start_seen, start_exp);
    chk("run_busy", bus.busy, 1);
    if (busy_byte) begin send_byte(8'h55); err_exp++; end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    chk("run_no_early_tx", exp_tx.size(), 2 * m_n);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    t = 0;
    while (bus.busy && t < 300) begin @(negedge clk); t++; end
    if (bus.busy) fail("run_timeout", t);
    chk("run_busy_end", bus.busy, 0);
    chk("run_tx_left", exp_tx.size(), 0);
  endtask

  // Event monitor: writes, err and start pulses.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (bus.err) err_seen++;
      if (bus.start) start_seen++;
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) fail("wr_unexpected", int'({bus.wr_sel, bus.wr_addr, bus.wr_data}));
        else chk("wr_sel_addr_data", int'({bus.wr_sel, bus.wr_addr, bus.wr_data}), int'(exp_wr.pop_front()));
      end
    end
  end

  // Transmit sink: applies backpressure, checks bytes and hold stability.
  initial begin : txsink
    logic [7:0] pd;
    bit pv;
    int stall, need;
    pv = 1'b0; pd = '0; stall = 0; need = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pv) begin
        chk("tx_hold_valid", bus.tx_valid, 1);
        chk("tx_hold_data", bus.tx_data, pd);
      end
      if (bus.tx_valid) begin
        if (!pv) begin
          stall = 0;
          if (tx_mode == 2)      need = (tx_bidx == 1) ? 3 : 0;
          else if (tx_mode == 1) need = $urandom_range(0, 2);
          else                   need = 0;
        end
        bus.tx_ready = (stall >= need);
        if (bus.tx_ready) begin
          if (exp_tx.size() == 0) fail("tx_unexpected", bus.tx_data);
          else chk("tx_byte", bus.tx_data, exp_tx.pop_front());
          tx_bidx++;
          pv = 1'b0;
        end else begin
          stall++;
          pv = 1'b1;
          pd = bus.tx_data;
        end
      end else begin
        pv = 1'b0;
        bus.tx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] f[$];
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.done     = 1'b0;
    for (int i = 0; i < MAX_N; i++) res_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    f = '{8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("setn4");
    f = '{8'hFE, 8'h05, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("vec");
    f = '{8'hFE, 8'h06, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("row");
    f = '{8'hFE, 8'h06, 8'h03, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("row_err");

    f = '{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("setn2");
    res_mem[0] = 16'h1234;
    res_mem[1] = 16'hABCD;
    do_run(2, 1'b1);
    settle_check("run");

    f = '{8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("setn9");
    f = '{8'hFE, 8'h01, 8'h04, 8'h00};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("bad_tail");
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    settle_check("stray_done");

    f = '{8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("setn4b");
    exp_wr.push_back({1'b0, 6'd0, 8'h0A});
    exp_wr.push_back({1'b0, 6'd1, 8'h0B});
    f = '{8'hFE, 8'h05, 8'h02, 8'h0A, 8'h0B};
    send_frame(f, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset("midrst");
    chk("midrst_wr_left", exp_wr.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    m_n = MAX_N;
    @(negedge clk);
    f = '{8'hFE, 8'h09, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEF};
    void'(model_frame(f)); send_frame(f, 1'b0); settle_check("after_rst");

    for (int it = 0; it < 40; it++) begin
      logic [7:0] rf[$];
      logic [7:0] cmd, len;
      int k, np;
      k = $urandom_range(0, 9);
      if (k >= 8) begin
        for (int i = 0; i < MAX_N; i++) res_mem[i] = 16'($urandom);
        do_run(1, $urandom_range(0, 1) == 1);
      end else begin
        if (k < 2)      begin cmd = 8'h01; np = 1; end
        else if (k < 5) begin cmd = 8'h02; np = m_n; end
        else            begin cmd = 8'h03; np = m_n + 1; end
        len = 8'(np + 1);
        if ($urandom_range(0, 7) == 0) len = len + 8'd1;
        rf = '{8'hFE, len, cmd};
        for (int j = 0; j < np; j++) rf.push_back(8'($urandom_range(0, 253)));
        if (cmd == 8'h01)
          rf[3] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(1, MAX_N));
        if (cmd == 8'h03)
          rf[3] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(m_n, 15)) : 8'($urandom_range(0, m_n - 1));
        rf.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 8'hED)) : 8'hEF);
        void'(model_frame(rf));
        send_frame(rf, 1'b1);
      end
      settle_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mxv_cmd_scheduler.md
Name: mxv_cmd_scheduler

Overview:
- Command-level controller for the matrix-vector (MxV) engine.
- Consumes bytes delivered by the UART receive path and parses framed commands.
- From those commands it sets the matrix size N, writes the matrix and vector memories, and starts the MxV datapath.
- When the datapath reports done, it streams the N results to the UART transmit path over a valid/ready handshake.

Parameters:
- MAX_N, 8, maximum matrix dimension; legal N is 1..MAX_N.
- DATA_W, 8, width of matrix/vector elements; equals the UART byte width.
- RES_W, 16, width of each result; must be a multiple of 8.
- ADDR_W, $clog2(MAX_N*MAX_N), width of the memory write address.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- n_size  out  $clog2(MAX_N+1)  current N
- wr_en  out  1  memory write strobe
- wr_sel  out  1  write target: 0 = vector, 1 = matrix
- wr_addr  out  ADDR_W  vector: col; matrix: row*MAX_N+col
- wr_data  out  DATA_W  write data
- start  out  1  one-cycle pulse to the MxV datapath
- done  in  1  datapath completion pulse
- res_addr  out  $clog2(MAX_N)  result memory read address; read latency is 1 cycle
- res_data  in  RES_W  result memory read data
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts the byte
- busy  out  1  executing or transmitting
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset and clock: reset is asynchronous, active-low; clk is the clock.
- Reset values: all outputs 0, except n_size = MAX_N; FSM in IDLE. Reset mid-operation abandons the frame with no further writes.
- Frame format: 0xFE, LEN, CMD, payload..., 0xEF.
  - LEN counts the CMD byte plus the payload bytes.
- Commands (required LEN in parentheses):
  - 0x01 SET_N (2): payload is N.
  - 0x02 LOAD_VEC (1+N): payload is N elements.
  - 0x03 LOAD_ROW (2+N): payload is row index, then N elements.
  - 0x04 RUN (1): no payload.
- FSM states and transitions:
  - IDLE: a byte equal to 0xFE moves to GETLEN; any other byte is ignored silently.
  - GETLEN: latches LEN and moves to GETCMD.
  - GETCMD: an unknown CMD or a LEN mismatch raises err and returns to IDLE. Otherwise moves to ROWIDX (0x03), PAYLOAD (0x01/0x02), or TAIL (0x04).
  - ROWIDX: a row index >= N raises err and returns to IDLE. Otherwise latches the row and moves to PAYLOAD.
  - PAYLOAD: for 0x01, the byte is held as pending N. For 0x02/0x03, each byte produces wr_en for one cycle, in the cycle after its rx_valid. A column counter counts 0..N-1. After N bytes, moves to TAIL.
  - TAIL: a byte equal to 0xEF commits the command; otherwise err and return to IDLE.
    - SET_N: commits only if pending N is in 1..MAX_N; otherwise err.
    - RUN: moves to EXEC.
  - EXEC: start is pulsed on the first cycle of EXEC. The FSM then waits for done. When done arrives, res_addr = 0 and the FSM moves to TXLOAD.
  - TXLOAD: one cycle for the read latency. Captures res_data into a shift register and moves to TXBYTE.
  - TXBYTE: tx_data is the MSB byte of the shift register and tx_valid is held until tx_ready.
    - On tx_valid && tx_ready: shift left 8. After RES_W/8 bytes, either increment res_addr and return to TXLOAD, or return to IDLE if res_addr == N-1.
    - tx_data/tx_valid are stable while tx_ready is low.
- Error and edge rules:
  - Writes already issued in PAYLOAD are not rolled back on a later error.
  - busy = 1 in EXEC, TXLOAD and TXBYTE. rx_valid during busy: the byte is dropped and err pulses.
  - done outside EXEC is ignored.
  - rx_valid on consecutive cycles must be handled; the FSM consumes one byte per cycle.
  - A SET_N commit does not clear the memories.

Decomposition:
- Package mxv_pkg holds:
  - the state enum;
  - constants SOF = 8'hFE, EOF = 8'hEF;
  - CMD_SET_N, CMD_LOAD_VEC, CMD_LOAD_ROW, CMD_RUN.
- One natural sub-module, mxv_tx_serializer: TXLOAD/TXBYTE shift register plus byte counter, taking a load/ready handshake from the main FSM.

Test Plan:
- Reset, then frame FE 02 01 04 EF -> n_size = 4, no err, no wr_en.
- With N=4, send FE 05 02 0A 0B 0C 0D EF -> four wr_en pulses with wr_sel = 0, addr 0..3, data 0A..0D.
- With N=4, send FE 06 03 02 11 22 33 44 EF -> wr_sel = 1, addr 16..19.
  - Then FE 06 03 05 ... -> err pulse at the row byte, no writes.
- Run with N=2 and results 0x1234, 0xABCD:
  - FE 01 04 EF -> exactly one start pulse; busy = 1.
  - After done: tx bytes 12 34 AB CD in order, with tx_ready held low 3 cycles on byte 2 and tx_data stable throughout.
  - busy = 0 after the last byte.
- Error frames:
  - FE 02 01 09 EF (N = 9 > MAX_N) -> err pulse; n_size unchanged.
  - Wrong tail FE 01 04 00 -> err pulse, no start.
  - A byte during busy -> err pulse.
- Assert reset mid-LOAD_VEC after 2 bytes -> all outputs 0 and n_size = MAX_N. A subsequent full frame is then parsed correctly.
